// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversamples MDC/MDIO in the clk_int domain,
// decodes read/write frames for PHY_ADDR and serves a 16 x 16-bit register file.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR  = 5'd1,
    parameter logic [15:0] REG0_RST  = 16'h1140,
    parameter logic [15:0] REG1_BASE = 16'h7949,
    parameter logic [15:0] PHY_ID1   = 16'h0141,
    parameter logic [15:0] PHY_ID2   = 16'h0DD1
) (
    input  logic        clk_int,
    input  logic        rst_int,
    input  logic        phy_mdc,
    input  logic        phy_mdio_i,
    output logic        phy_mdio_o,
    output logic        phy_mdio_oe,
    input  logic        link_up,
    output logic        cfg_loopback,
    output logic        wr_strobe,
    output logic [4:0]  wr_regad,
    output logic [15:0] wr_data
);

    typedef enum logic [2:0] {
        S_PRE   = 3'd0,
        S_START = 3'd1,
        S_OP    = 3'd2,
        S_ADDR  = 3'd3,
        S_TA    = 3'd4,
        S_DATA  = 3'd5
    } state_t;

    logic [2:0]  mdc_sync_q;
    logic [1:0]  mdio_sync_q;
    state_t      state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        op_first_q, op_first_d;
    logic        op_read_q, op_read_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [4:0]  wr_regad_q, wr_regad_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] rf_q [16];
    logic [15:0] rf_d [16];

    logic        mdc_rise_s;
    logic        mdc_fall_s;
    logic        mdio_bit_s;
    logic        match_s;
    logic [4:0]  regad_s;
    logic [15:0] wdata_s;
    logic [15:0] rd_val_s;

    assign mdc_rise_s = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign mdc_fall_s = ~mdc_sync_q[1] & mdc_sync_q[2];
    assign mdio_bit_s = mdio_sync_q[1];
    assign match_s    = (addr_q[9:5] == PHY_ADDR);
    assign regad_s    = addr_q[4:0];
    assign wdata_s    = {data_q[14:0], mdio_bit_s};

    assign phy_mdio_o   = mdio_o_q;
    assign phy_mdio_oe  = mdio_oe_q;
    assign wr_strobe    = wr_strobe_q;
    assign wr_regad     = wr_regad_q;
    assign wr_data      = wr_data_q;
    assign cfg_loopback = rf_q[0][14];

    // Register-file read mux; bit 15 of the control register always reads back as 0
    always_comb begin
        rd_val_s = 16'h0000;
        case (regad_s)
            5'd0:    rd_val_s = rf_q[0] & 16'h7FFF;
            5'd1:    rd_val_s = {REG1_BASE[15:3], link_up, REG1_BASE[1:0]};
            5'd2:    rd_val_s = PHY_ID1;
            5'd3:    rd_val_s = PHY_ID2;
            default: begin
                if (regad_s[4]) begin
                    rd_val_s = 16'h0000;
                end else begin
                    rd_val_s = rf_q[regad_s[3:0]];
                end
            end
        endcase
    end

    // Frame decoder: state advances on MDC rise, drive changes only on MDC fall
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        op_first_d  = op_first_q;
        op_read_d   = op_read_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        wr_strobe_d = 1'b0;
        wr_regad_d  = wr_regad_q;
        wr_data_d   = wr_data_q;
        rf_d        = rf_q;

        if (mdc_rise_s) begin
            case (state_q)
                S_PRE: begin
                    if (mdio_bit_s) begin
                        if (pre_cnt_q != 6'd32) begin
                            pre_cnt_d = pre_cnt_q + 6'd1;
                        end else begin
                            pre_cnt_d = pre_cnt_q;
                        end
                    end else begin
                        if (pre_cnt_q == 6'd32) begin
                            state_d = S_START;
                        end else begin
                            state_d = S_PRE;
                        end
                        pre_cnt_d = 6'd0;
                    end
                end
                S_START: begin
                    if (mdio_bit_s) begin
                        state_d   = S_OP;
                        bit_cnt_d = 5'd0;
                    end else begin
                        state_d   = S_PRE;
                        pre_cnt_d = 6'd0;
                    end
                end
                S_OP: begin
                    if (bit_cnt_q == 5'd0) begin
                        op_first_d = mdio_bit_s;
                        bit_cnt_d  = 5'd1;
                    end else if (op_first_q != mdio_bit_s) begin
                        op_read_d = op_first_q;
                        state_d   = S_ADDR;
                        bit_cnt_d = 5'd0;
                    end else begin
                        state_d   = S_PRE;
                        pre_cnt_d = 6'd0;
                        bit_cnt_d = 5'd0;
                    end
                end
                S_ADDR: begin
                    addr_d = {addr_q[8:0], mdio_bit_s};
                    if (bit_cnt_q == 5'd9) begin
                        state_d   = S_TA;
                        bit_cnt_d = 5'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = 5'd0;
                        if (op_read_q && match_s) begin
                            data_d = rd_val_s;
                        end else begin
                            data_d = data_q;
                        end
                    end
                end
                S_DATA: begin
                    if (!op_read_q) begin
                        data_d = wdata_s;
                    end else begin
                        data_d = data_q;
                    end
                    if (bit_cnt_q == 5'd15) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 6'd0;
                        bit_cnt_d = 5'd0;
                        if (!op_read_q && match_s) begin
                            // Soft reset (reg 0 bit 15) discards the data but still strobes
                            if (regad_s == 5'd0) begin
                                wr_strobe_d = 1'b1;
                                wr_regad_d  = regad_s;
                                wr_data_d   = wdata_s;
                                if (wdata_s[15]) begin
                                    rf_d[0] = REG0_RST;
                                    for (int i = 4; i < 16; i++) begin
                                        rf_d[i] = 16'h0000;
                                    end
                                end else begin
                                    rf_d[0] = wdata_s;
                                end
                            end else if (!regad_s[4] && (regad_s[3:2] != 2'b00)) begin
                                wr_strobe_d          = 1'b1;
                                wr_regad_d           = regad_s;
                                wr_data_d            = wdata_s;
                                rf_d[regad_s[3:0]]   = wdata_s;
                            end else begin
                                wr_strobe_d = 1'b0;
                            end
                        end else begin
                            wr_strobe_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d   = S_PRE;
                    pre_cnt_d = 6'd0;
                end
            endcase
        end else if (mdc_fall_s) begin
            case (state_q)
                S_TA: begin
                    if ((bit_cnt_q == 5'd1) && op_read_q && match_s) begin
                        mdio_oe_d = 1'b1;
                        mdio_o_d  = 1'b0;
                    end else begin
                        mdio_oe_d = mdio_oe_q;
                    end
                end
                S_DATA: begin
                    if (op_read_q && match_s) begin
                        mdio_o_d = data_q[15];
                        data_d   = {data_q[14:0], 1'b0};
                    end else begin
                        mdio_o_d = mdio_o_q;
                    end
                end
                default: begin
                    mdio_oe_d = 1'b0;
                    mdio_o_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Synchronizers, edge-detect flop, FSM and register file state
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            mdc_sync_q  <= 3'b000;
            mdio_sync_q <= 2'b00;
            state_q     <= S_PRE;
            pre_cnt_q   <= 6'd0;
            bit_cnt_q   <= 5'd0;
            op_first_q  <= 1'b0;
            op_read_q   <= 1'b0;
            addr_q      <= 10'd0;
            data_q      <= 16'h0000;
            mdio_o_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_regad_q  <= 5'd0;
            wr_data_q   <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= (i == 0) ? REG0_RST : 16'h0000;
            end
        end else begin
            mdc_sync_q  <= {mdc_sync_q[1:0], phy_mdc};
            mdio_sync_q <= {mdio_sync_q[0], phy_mdio_i};
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            op_first_q  <= op_first_d;
            op_read_q   <= op_read_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_regad_q  <= wr_regad_d;
            wr_data_q   <= wr_data_d;
            rf_q        <= rf_d;
        end
    end

endmodule
